// File: rtl/io_ctrl.sv
// io_ctrl: memory-mapped KEY/SW/HEX/LED controller decoding the FFF0-FFFF window.
// Defining IO_TIMER_EN adds a prescaled 16-bit timer at FFF6; otherwise FFF6 reads zero.
module io_ctrl #(
    parameter int DBITS       = 16,
    parameter int DEB_CYCLES  = 500000,
    parameter int DEB_BITS    = 19,
    parameter int TICK_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DBITS-1:0] addr,
    input  logic [DBITS-1:0] wdata,
    input  logic             we,
    input  logic             rd,
    output logic             sel,
    output logic [DBITS-1:0] rdata,
    input  logic [3:0]       key_in,
    input  logic [9:0]       sw_in,
    output logic [15:0]      hex_out,
    output logic [9:0]       ledr,
    output logic [7:0]       ledg
);

    typedef enum logic {STABLE, COUNTING} deb_state_t;

    localparam logic [DEB_BITS-1:0] DEB_LAST = DEB_BITS'(DEB_CYCLES - 1);

    logic [3:0]          reg_off;
    logic                store;
    logic [7:0]          kctrl_clr;
    logic [3:0]          key_meta, key_sync;
    logic [9:0]          sw_meta, sw_sync;
    logic [3:0]          kstable, kstable_nxt, kstable_d;
    deb_state_t          deb_state [4];
    deb_state_t          deb_state_nxt [4];
    logic [DEB_BITS-1:0] deb_cnt [4];
    logic [DEB_BITS-1:0] deb_cnt_nxt [4];
    logic [3:0]          kedge, rise;
    logic                rdy, ovr, key_evt;
    logic [DBITS-1:0]    tcnt_rd;
    logic                unused_rd;

    // rd is reserved for a future read-to-clear register and has no effect today
    assign unused_rd = rd;

    assign sel       = (addr[DBITS-1:4] == {(DBITS-4){1'b1}});
    assign reg_off   = addr[3:0];
    assign store     = we && sel;
    assign kctrl_clr = (store && reg_off == 4'h4) ? wdata[7:0] : 8'h00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_meta <= '0;
            key_sync <= '0;
            sw_meta  <= '0;
            sw_sync  <= '0;
        end else begin
            key_meta <= ~key_in;
            key_sync <= key_meta;
            sw_meta  <= sw_in;
            sw_sync  <= sw_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kstable   <= '0;
            kstable_d <= '0;
            for (int i = 0; i < 4; i++) begin
                deb_state[i] <= STABLE;
                deb_cnt[i]   <= '0;
            end
        end else begin
            kstable   <= kstable_nxt;
            kstable_d <= kstable;
            for (int i = 0; i < 4; i++) begin
                deb_state[i] <= deb_state_nxt[i];
                deb_cnt[i]   <= deb_cnt_nxt[i];
            end
        end
    end

    // Any cycle where the synced pin agrees with kstable restarts the count,
    // so only an unbroken run of DEB_CYCLES disagreeing samples is accepted.
    always_comb begin
        kstable_nxt = kstable;
        for (int i = 0; i < 4; i++) begin
            deb_state_nxt[i] = deb_state[i];
            deb_cnt_nxt[i]   = deb_cnt[i];
            if (key_sync[i] == kstable[i]) begin
                deb_state_nxt[i] = STABLE;
                deb_cnt_nxt[i]   = '0;
            end else if (deb_cnt[i] == DEB_LAST) begin
                kstable_nxt[i]   = key_sync[i];
                deb_state_nxt[i] = STABLE;
                deb_cnt_nxt[i]   = '0;
            end else begin
                deb_state_nxt[i] = COUNTING;
                deb_cnt_nxt[i]   = (deb_state[i] == STABLE) ? DEB_BITS'(1) : deb_cnt[i] + 1'b1;
            end
        end
    end

    assign rise    = kstable & ~kstable_d;
    assign key_evt = |rise;

    // A new press in the same cycle as a write-1-to-clear keeps its bit set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kedge <= '0;
            rdy   <= 1'b0;
            ovr   <= 1'b0;
        end else begin
            kedge <= (kedge & ~kctrl_clr[7:4]) | rise;
            rdy   <= (rdy & ~kctrl_clr[0]) | key_evt;
            ovr   <= (ovr & ~kctrl_clr[1]) | (key_evt & rdy);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hex_out <= '0;
            ledr    <= '0;
            ledg    <= '0;
        end else if (store) begin
            if (reg_off == 4'h8) hex_out <= wdata[15:0];
            if (reg_off == 4'hA) ledr    <= wdata[9:0];
            if (reg_off == 4'hC) ledg    <= wdata[7:0];
        end
    end

`ifdef IO_TIMER_EN
    localparam int TICK_BITS = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    logic [TICK_BITS-1:0] presc;
    logic [15:0]          tcnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            tcnt  <= '0;
        end else if (store && reg_off == 4'h6) begin
            presc <= '0;
            tcnt  <= wdata[15:0];
        end else if (presc == TICK_BITS'(TICK_CYCLES - 1)) begin
            presc <= '0;
            tcnt  <= tcnt + 16'd1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    assign tcnt_rd = DBITS'(tcnt);
`else
    localparam int unused_tick_cycles = TICK_CYCLES;

    assign tcnt_rd = '0;
`endif

    always_comb begin
        rdata = DBITS'(16'hDEAD);
        if (sel) begin
            case (reg_off)
                4'h0:    rdata = DBITS'(kstable);
                4'h2:    rdata = DBITS'(sw_sync);
                4'h4:    rdata = DBITS'({kedge, 2'b00, ovr, rdy});
                4'h6:    rdata = tcnt_rd;
                4'h8:    rdata = DBITS'(hex_out);
                4'hA:    rdata = DBITS'(ledr);
                4'hC:    rdata = DBITS'(ledg);
                default: rdata = DBITS'(16'hDEAD);
            endcase
        end
    end

endmodule

// File: tb/tb_io_ctrl.sv
// tb_io_ctrl: directed and randomized checks of io_ctrl against a behavioural model.
// Built with or without IO_TIMER_EN; timer expectations follow the macro.
module tb_io_ctrl;

    localparam int DEB  = 4;
    localparam int TICK = 5;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] addr  = 16'hFFF8;
    logic [15:0] wdata = 16'h0000;
    logic        we    = 1'b0;
    logic        rd    = 1'b0;
    logic        sel;
    logic [15:0] rdata;
    logic [3:0]  key_in = 4'hF;
    logic [9:0]  sw_in  = 10'h000;
    logic [15:0] hex_out;
    logic [9:0]  ledr;
    logic [7:0]  ledg;

    int   checks = 0;
    int   errors = 0;
    logic cmp_en = 1'b0;

    io_ctrl #(
        .DBITS(16), .DEB_CYCLES(DEB), .DEB_BITS(3), .TICK_CYCLES(TICK)
    ) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .we(we), .rd(rd),
        .sel(sel), .rdata(rdata), .key_in(key_in), .sw_in(sw_in),
        .hex_out(hex_out), .ledr(ledr), .ledg(ledg)
    );

    always #5 clk = ~clk;

    // Reference state: pressed-pin history, run length of disagreement, and the map contents
    logic [3:0]  kpipe_m = '0, ksync_m = '0, kst_m = '0, kprev_m = '0, kedge_m = '0;
    int          run_m [4] = '{0, 0, 0, 0};
    logic        rdy_m = 1'b0, ovr_m = 1'b0;
    logic [9:0]  swpipe_m = '0, swsync_m = '0;
    logic [15:0] hex_m = '0, tcnt_m = '0;
    logic [9:0]  ledr_m = '0;
    logic [7:0]  ledg_m = '0;
    int          tick_m = 0;
    logic [3:0]  rise_m;
    logic [7:0]  clr_m;
    logic        store_m;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kpipe_m = '0; ksync_m = '0; kst_m = '0; kprev_m = '0; kedge_m = '0;
            for (int i = 0; i < 4; i++) run_m[i] = 0;
            rdy_m = 1'b0; ovr_m = 1'b0; swpipe_m = '0; swsync_m = '0;
            hex_m = '0; ledr_m = '0; ledg_m = '0; tcnt_m = '0; tick_m = 0;
        end else begin
            rise_m  = kst_m & ~kprev_m;
            kprev_m = kst_m;
            for (int i = 0; i < 4; i++) begin
                if (ksync_m[i] != kst_m[i]) begin
                    run_m[i] = run_m[i] + 1;
                    if (run_m[i] == DEB) begin
                        kst_m[i] = ksync_m[i];
                        run_m[i] = 0;
                    end
                end else begin
                    run_m[i] = 0;
                end
            end
            store_m = we && (addr[15:4] == 12'hFFF);
            clr_m   = (store_m && addr[3:0] == 4'h4) ? wdata[7:0] : 8'h00;
            ovr_m   = (ovr_m && !clr_m[1]) || (rise_m != 0 && rdy_m);
            rdy_m   = (rdy_m && !clr_m[0]) || (rise_m != 0);
            kedge_m = (kedge_m & ~clr_m[7:4]) | rise_m;
            if (store_m && addr[3:0] == 4'h8) hex_m  = wdata;
            if (store_m && addr[3:0] == 4'hA) ledr_m = wdata[9:0];
            if (store_m && addr[3:0] == 4'hC) ledg_m = wdata[7:0];
            if (store_m && addr[3:0] == 4'h6) begin
                tcnt_m = wdata;
                tick_m = 0;
            end else begin
                tick_m = tick_m + 1;
                if (tick_m == TICK) begin
                    tcnt_m = tcnt_m + 16'd1;
                    tick_m = 0;
                end
            end
            ksync_m  = kpipe_m;
            kpipe_m  = ~key_in;
            swsync_m = swpipe_m;
            swpipe_m = sw_in;
        end
    end

    function automatic logic [15:0] exp_rdata(input logic [15:0] a);
        if (a[15:4] != 12'hFFF) return 16'hDEAD;
        case (a[3:0])
            4'h0:    return {12'h000, kst_m};
            4'h2:    return {6'b0, swsync_m};
            4'h4:    return {8'h00, kedge_m, 2'b00, ovr_m, rdy_m};
`ifdef IO_TIMER_EN
            4'h6:    return tcnt_m;
`else
            4'h6:    return 16'h0000;
`endif
            4'h8:    return hex_m;
            4'hA:    return {6'b0, ledr_m};
            4'hC:    return {8'h00, ledg_m};
            default: return 16'hDEAD;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] d, input logic w, input logic r);
        addr  = a;
        wdata = d;
        we    = w;
        rd    = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic store(input logic [15:0] a, input logic [15:0] d);
        applyStimulus(a, d, 1'b1, 1'b0);
        tick();
        applyStimulus(a, d, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            checkOutput("sel", {15'b0, sel}, {15'b0, addr[15:4] == 12'hFFF});
            checkOutput("rdata", rdata, exp_rdata(addr));
            checkOutput("hex_out", hex_out, hex_m);
            checkOutput("ledr", {6'b0, ledr}, {6'b0, ledr_m});
            checkOutput("ledg", {8'b0, ledg}, {8'b0, ledg_m});
        end
    end

    initial begin
        logic [15:0] ra;
        int          k;
        logic [15:0] t0, t1;
`ifdef IO_TIMER_EN
        t0 = 16'h0005;
        t1 = 16'hFFFF;
`else
        t0 = 16'h0000;
        t1 = 16'h0000;
`endif
        applyStimulus(16'hFFF8, 16'h1234, 1'b1, 1'b0);
        cmp_en = 1'b1;
        tick();
        tick();
        applyStimulus(16'hFFF4, 16'h1234, 1'b1, 1'b0);
        #1;
        checkOutput("rst_hex", hex_out, 16'h0000);
        checkOutput("rst_ledr", {6'b0, ledr}, 16'h0000);
        checkOutput("rst_ledg", {8'b0, ledg}, 16'h0000);
        checkOutput("rst_kctrl", rdata, 16'h0000);

        applyStimulus(16'hFFF6, 16'h0000, 1'b0, 1'b0);
        rst_n = 1'b1;
        repeat (25) tick();
        #1 checkOutput("tcnt_25", rdata, t0);
        store(16'hFFF6, 16'hFFFF);
        repeat (4) tick();
        #1 checkOutput("tcnt_load", rdata, t1);
        tick();
        #1 checkOutput("tcnt_wrap", rdata, 16'h0000);

        store(16'hFFF8, 16'hBEEF);
        #1 checkOutput("hex_next", hex_out, 16'hBEEF);
        store(16'hFFFA, 16'h03FF);
        store(16'hFFFC, 16'h00A5);
        #1;
        checkOutput("ledr_next", {6'b0, ledr}, 16'h03FF);
        checkOutput("ledg_next", {8'b0, ledg}, 16'h00A5);
        applyStimulus(16'hFFFA, 16'h0000, 1'b0, 1'b1);
        #1 checkOutput("load_ledr", rdata, 16'h03FF);

        applyStimulus(16'hFFF0, 16'h0000, 1'b0, 1'b0);
        key_in = 4'b1101;
        repeat (5) tick();
        #1 checkOutput("kdata_early", rdata, 16'h0000);
        tick();
        #1 checkOutput("kdata_c6", rdata, 16'h0002);
        applyStimulus(16'hFFF4, 16'h0000, 1'b0, 1'b0);
        tick();
        #1 checkOutput("kctrl_key1", rdata, 16'h0021);
        repeat (3) tick();
        key_in = 4'hF;
        repeat (8) tick();
        applyStimulus(16'hFFF0, 16'h0000, 1'b0, 1'b0);
        #1 checkOutput("kdata_release", rdata, 16'h0000);

        key_in = 4'b1101;
        repeat (2) tick();
        key_in = 4'hF;
        repeat (10) tick();
        #1 checkOutput("kdata_glitch", rdata, 16'h0000);

        store(16'hFFF4, 16'h00FF);
        #1 checkOutput("kctrl_clear", rdata, 16'h0000);
        key_in = 4'b1110;
        repeat (8) tick();
        key_in = 4'b1010;
        repeat (8) tick();
        #1 checkOutput("kctrl_ovr", rdata, 16'h0053);
        store(16'hFFF4, 16'h0013);
        #1 checkOutput("kctrl_w1c", rdata, 16'h0040);
        key_in = 4'hF;
        repeat (8) tick();
        key_in = 4'b0111;
        repeat (6) tick();
        store(16'hFFF4, 16'h0001);
        #1 checkOutput("kctrl_setwins", rdata, 16'h00C1);
        key_in = 4'hF;
        repeat (8) tick();

        applyStimulus(16'hFFF2, 16'h0000, 1'b0, 1'b1);
        sw_in = 10'h2AA;
        tick();
        #1 checkOutput("sdata_1cyc", rdata, 16'h0000);
        tick();
        #1 checkOutput("sdata_2cyc", rdata, 16'h02AA);

        applyStimulus(16'hFFEE, 16'h0000, 1'b0, 1'b1);
        #1;
        checkOutput("dead_nosel", rdata, 16'hDEAD);
        checkOutput("sel_low", {15'b0, sel}, 16'h0000);
        applyStimulus(16'hFFFE, 16'h0000, 1'b0, 1'b1);
        #1;
        checkOutput("dead_fffe", rdata, 16'hDEAD);
        checkOutput("sel_high", {15'b0, sel}, 16'h0001);

        key_in = 4'b1110;
        repeat (4) tick();
        applyStimulus(16'hFFF8, 16'h1234, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1 checkOutput("midrst_hex", hex_out, 16'h0000);
        tick();
        rst_n = 1'b1;
        applyStimulus(16'hFFF0, 16'h0000, 1'b0, 1'b0);
        #1 checkOutput("midrst_kdata", rdata, 16'h0000);

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) ra = 16'($urandom);
            else ra = {12'hFFF, 4'($urandom_range(0, 15))};
            applyStimulus(ra, 16'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 9) == 0) begin
                k = int'($urandom_range(0, 3));
                key_in[k] = ~key_in[k];
            end
            if ($urandom_range(0, 19) == 0) sw_in = 10'($urandom);
            if (c == 1500) rst_n = 1'b0;
            if (c == 1502) rst_n = 1'b1;
            tick();
        end

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
